// File: rtl/stream_throttle_pkg.sv
// Purpose: shared width helpers and credit clamping for the stream throttle arbiter.
// Latency: n/a (compile-time and combinational helpers only).
// Backpressure: n/a.
package stream_throttle_pkg;

    // Index width for a requester count; a single requester still gets one bit.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // Counter width able to hold 0..max_pending inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_pending);
        return $clog2(max_pending + 1);
    endfunction

    // Runtime limit clamped to the compile-time outstanding capacity.
    function automatic int unsigned min_credit(input int unsigned credit,
                                               input int unsigned max_pending);
        return (credit < max_pending) ? credit : max_pending;
    endfunction

endpackage

// File: rtl/stream_throttle_id_fifo.sv
// Purpose: ordered record of which requester owns each in-flight transfer.
// Latency: push visible at head one cycle later; no fall-through.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module stream_throttle_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;

    logic [Width-1:0]    mem [Depth];
    ptr_t                wr_ptr;
    ptr_t                rd_ptr;
    logic [CntWidth-1:0] count;
    logic                do_push;
    logic                do_pop;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CntWidth'(Depth));
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/stream_throttle_arbiter.sv
// Purpose: round-robin N:1 request arbiter with a runtime in-flight limit and in-order response return.
// Latency: zero-cycle combinational request and response paths; state updates on handshakes.
// Backpressure: grants stop while pending >= min(credit_i, MaxNumPending); rsp_ready_o follows the owning requester.
// Option: STREAM_THROTTLE_ARBITER_LOCK_EN holds a stalled presentation until its handshake.
module stream_throttle_arbiter
    import stream_throttle_pkg::*;
#(
    parameter int unsigned NumInp        = 2,
    parameter int unsigned MaxNumPending = 4,
    parameter int unsigned IdxWidth      = idx_width(NumInp),
    parameter int unsigned CntWidth      = cnt_width(MaxNumPending)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumInp-1:0]   req_valid_i,
    output logic [NumInp-1:0]   req_ready_o,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [IdxWidth-1:0] req_idx_o,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    output logic [NumInp-1:0]   rsp_valid_o,
    input  logic [NumInp-1:0]   rsp_ready_i,
    output logic [IdxWidth-1:0] rsp_idx_o,
    input  logic [CntWidth-1:0] credit_i,
    output logic [CntWidth-1:0] pending_o
);
    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    cnt_t pending_q;
    cnt_t credit_lim;
    idx_t rr_ptr_q;
    idx_t rr_win;
    idx_t sel_idx;
    idx_t fifo_head;
    logic any_vld;
    logic sel_vld;
    logic credit_ok;
    logic req_hs;
    logic rsp_hs;
    logic fifo_empty;
    logic fifo_full;

    // (base + offs) mod NumInp, for offs < NumInp.
    function automatic idx_t wrap_idx(input idx_t base, input int unsigned offs);
        int unsigned sum;
        sum = 32'(base) + offs;
        if (sum >= NumInp) sum = sum - NumInp;
        return idx_t'(sum);
    endfunction

    assign credit_lim = cnt_t'(min_credit(32'(credit_i), MaxNumPending));
    assign credit_ok  = (pending_q < credit_lim) & ~fifo_full;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        any_vld = 1'b0;
        rr_win  = rr_ptr_q;
        for (int unsigned i = 0; i < NumInp; i++) begin
            if (!any_vld && req_valid_i[wrap_idx(rr_ptr_q, i)]) begin
                any_vld = 1'b1;
                rr_win  = wrap_idx(rr_ptr_q, i);
            end
        end
    end

`ifdef STREAM_THROTTLE_ARBITER_LOCK_EN
    logic lock_q;
    idx_t lock_idx_q;

    // A stalled presentation stays valid and keeps its index, even if credit drops meanwhile.
    assign sel_vld = lock_q | (any_vld & credit_ok);
    assign sel_idx = lock_q ? lock_idx_q : rr_win;

    // Remember a presentation the downstream did not accept this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= sel_vld & ~req_ready_i;
            lock_idx_q <= sel_idx;
        end
    end
`else
    assign sel_vld = any_vld & credit_ok;
    assign sel_idx = rr_win;
`endif

    assign req_valid_o = sel_vld;
    assign req_idx_o   = sel_idx;
    assign req_hs      = sel_vld & req_ready_i;

    // Ready goes back only to the requester currently presented downstream.
    always_comb begin
        req_ready_o          = '0;
        req_ready_o[sel_idx] = req_hs;
    end

    // Responses return in issue order; the FIFO head names their owner.
    assign rsp_idx_o   = fifo_empty ? '0 : fifo_head;
    assign rsp_ready_o = ~fifo_empty & rsp_ready_i[rsp_idx_o];
    assign rsp_hs      = rsp_valid_i & rsp_ready_o;

    // Route the downstream response valid to its owner only.
    always_comb begin
        rsp_valid_o            = '0;
        rsp_valid_o[rsp_idx_o] = rsp_valid_i & ~fifo_empty;
    end

    // In-flight count and round-robin pointer, both advanced by handshakes only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            case ({req_hs, rsp_hs})
                2'b10:   pending_q <= pending_q + cnt_t'(1);
                2'b01:   pending_q <= pending_q - cnt_t'(1);
                default: pending_q <= pending_q;
            endcase
            if (req_hs) rr_ptr_q <= wrap_idx(sel_idx, 1);
        end
    end

    assign pending_o = pending_q;

    stream_throttle_id_fifo #(
        .Depth (MaxNumPending),
        .Width (IdxWidth)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (req_hs),
        .push_data (sel_idx),
        .pop       (rsp_hs),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_stream_throttle_arbiter.sv
// Purpose: scoreboard bench for stream_throttle_arbiter against a queue-based reference model.
// Latency: stimulus applied 1ns after each rising edge, outputs checked on the falling edge.
// Backpressure: downstream ready, response valid/ready and credit are randomized after directed cases.
module tb_stream_throttle_arbiter;
    localparam int N    = 2;
    localparam int MAXP = 4;
    localparam int IW   = 1;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid_i;
    logic [N-1:0]  req_ready_o;
    logic          req_valid_o;
    logic          req_ready_i;
    logic [IW-1:0] req_idx_o;
    logic          rsp_valid_i;
    logic          rsp_ready_o;
    logic [N-1:0]  rsp_valid_o;
    logic [N-1:0]  rsp_ready_i;
    logic [IW-1:0] rsp_idx_o;
    logic [CW-1:0] credit_i;
    logic [CW-1:0] pending_o;

    always #5 clk = ~clk;

    stream_throttle_arbiter #(
        .NumInp        (N),
        .MaxNumPending (MAXP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .req_idx_o   (req_idx_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_idx_o   (rsp_idx_o),
        .credit_i    (credit_i),
        .pending_o   (pending_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Reference model: owners of in-flight transfers in issue order, next RR start, lock.
    int m_fifo[$];
    int m_rr       = 0;
    bit m_locked   = 1'b0;
    int m_lock_idx = 0;
    int last_grant = -1;

    // Expectations for the cycle currently driven.
    bit e_req_vld = 1'b0;
    int e_req_idx = 0;
    int e_pending = 0;
    bit e_rsp_any = 1'b0;
    int e_rsp_idx = 0;
    bit e_rsp_rdy = 1'b0;

    // Scoreboards: expected grant owners and expected routed response vectors.
    int sb_req[$];
    int sb_rsp[$];
    int exp_g;
    int exp_v;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict outputs, wait for the edge, advance the model.
    task automatic cycle(input bit rst_v, input logic [N-1:0] rv, input bit rdy, input int cr,
                         input bit rsv, input logic [N-1:0] rsr);
        int  lim;
        int  w;
        bit  found;
        bit  hs_req;
        bit  hs_rsp;
        rst         = rst_v;
        req_valid_i = rv;
        req_ready_i = rdy;
        credit_i    = CW'(cr);
        rsp_valid_i = rsv;
        rsp_ready_i = rsr;
        lim   = (cr > MAXP) ? MAXP : cr;
        found = 1'b0;
        w     = m_rr;
        for (int i = 0; i < N; i++) begin
            if (!found && rv[(m_rr + i) % N]) begin
                found = 1'b1;
                w     = (m_rr + i) % N;
            end
        end
        if (m_locked) begin
            e_req_vld = 1'b1;
            e_req_idx = m_lock_idx;
        end else begin
            e_req_vld = found && (m_fifo.size() < lim);
            e_req_idx = w;
        end
        e_pending = m_fifo.size();
        e_rsp_any = (m_fifo.size() != 0);
        e_rsp_idx = e_rsp_any ? m_fifo[0] : 0;
        e_rsp_rdy = e_rsp_any && rsr[e_rsp_idx];
        hs_req    = e_req_vld && rdy;
        hs_rsp    = e_rsp_any && rsv && e_rsp_rdy;
        if (hs_req) sb_req.push_back(e_req_idx);
        if (e_rsp_any && rsv) sb_rsp.push_back(1 << e_rsp_idx);
        last_grant = hs_req ? e_req_idx : -1;
        @(posedge clk);
        #1;
        if (rst_v) begin
            m_fifo.delete();
            m_rr     = 0;
            m_locked = 1'b0;
        end else begin
            if (hs_rsp) void'(m_fifo.pop_front());
            if (hs_req) begin
                m_fifo.push_back(e_req_idx);
                m_rr = (e_req_idx + 1) % N;
            end
`ifdef STREAM_THROTTLE_ARBITER_LOCK_EN
            m_locked   = e_req_vld && !rdy;
            m_lock_idx = e_req_idx;
`endif
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (m_fifo.size() != 0 || m_locked); k++)
            cycle(1'b0, '0, 1'b1, 4, m_fifo.size() != 0, '1);
    endtask

    // Monitor: compares DUT outputs on the falling edge and pops scoreboards on handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            check("pending_o", int'(pending_o), e_pending);
            check("req_valid_o", int'(req_valid_o), int'(e_req_vld));
            if (e_req_vld) check("req_idx_o", int'(req_idx_o), e_req_idx);
            check("rsp_ready_o", int'(rsp_ready_o), int'(e_rsp_rdy));
            if (e_rsp_any) check("rsp_idx_o", int'(rsp_idx_o), e_rsp_idx);
            if (rsp_valid_i) check("rsp_protocol_nonempty", int'(pending_o != '0), 1);
            if (req_valid_o && req_ready_i) begin
                if (sb_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_sb: unexpected grant to %0d, none required", req_idx_o);
                end else begin
                    exp_g = sb_req.pop_front();
                    check("grant_idx", int'(req_idx_o), exp_g);
                    check("grant_ready_o", int'(req_ready_o), 1 << exp_g);
                end
            end else begin
                check("req_ready_o_idle", int'(req_ready_o), 0);
            end
            if (rsp_valid_o != '0) begin
                if (sb_rsp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_sb: unexpected rsp_valid_o %0d, none required", rsp_valid_o);
                end else begin
                    exp_v = sb_rsp.pop_front();
                    check("rsp_valid_o", int'(rsp_valid_o), exp_v);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] hold;
        logic [N-1:0] rv;
        int           cr;
        int           g[4];

        // Reset and check the idle output state.
        cycle(1'b1, '0, 1'b0, 0, 1'b0, '0);
        cycle(1'b1, '0, 1'b0, 0, 1'b0, '0);
        rst = 1'b0; req_ready_i = 1'b1; rsp_ready_i = '1; credit_i = CW'(4);
        #1;
        check("rst_req_valid_o", int'(req_valid_o), 0);
        check("rst_req_ready_o", int'(req_ready_o), 0);
        check("rst_req_idx_o", int'(req_idx_o), 0);
        check("rst_rsp_valid_o", int'(rsp_valid_o), 0);
        check("rst_rsp_ready_o", int'(rsp_ready_o), 0);
        check("rst_rsp_idx_o", int'(rsp_idx_o), 0);
        check("rst_pending_o", int'(pending_o), 0);
        mon_en = 1'b1;

        // Both requesters valid, always ready: alternating grants until credit runs out.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b11, 1'b1, 4, 1'b0, '0);
            g[i] = last_grant;
        end
        for (int i = 0; i < 4; i++) check("t1_grant_order", g[i], i % 2);
        check("t1_pending_full", int'(pending_o), 4);
        check("t1_fifth_req_valid", int'(req_valid_o), 0);
        drain();

        // Credit 2: third request blocked, then granted the cycle after a response.
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b01, 1'b1, 2, 1'b0, '0);
        check("t2_blocked", last_grant, -1);
        check("t2_pending_cap", int'(pending_o), 2);
        cycle(1'b0, 2'b01, 1'b1, 2, 1'b1, 2'b11);
        check("t2_no_grant_same_cycle", last_grant, -1);
        cycle(1'b0, 2'b01, 1'b1, 2, 1'b0, '0);
        check("t2_grant_after_rsp", last_grant, 0);
        drain();

        // Grants 0,1,1 then in-order response routing with a stall on requester 1.
        cycle(1'b0, 2'b01, 1'b1, 4, 1'b0, '0);
        check("t3_grant0", last_grant, 0);
        cycle(1'b0, 2'b10, 1'b1, 4, 1'b0, '0);
        check("t3_grant1", last_grant, 1);
        cycle(1'b0, 2'b10, 1'b1, 4, 1'b0, '0);
        check("t3_grant2", last_grant, 1);
        cycle(1'b0, '0, 1'b0, 4, 1'b1, 2'b11);
        cycle(1'b0, '0, 1'b0, 4, 1'b1, 2'b01);
        check("t3_stall_pending", int'(pending_o), 2);
        cycle(1'b0, '0, 1'b0, 4, 1'b1, 2'b10);
        cycle(1'b0, '0, 1'b0, 4, 1'b1, 2'b10);
        check("t3_drained", int'(pending_o), 0);

        // Simultaneous request and response handshakes at pending 1.
        cycle(1'b0, 2'b01, 1'b1, 4, 1'b0, '0);
        cycle(1'b0, 2'b10, 1'b1, 4, 1'b1, 2'b11);
        check("t4_pending_same", int'(pending_o), 1);
        check("t4_head_advanced", int'(rsp_idx_o), 1);
        drain();

        // Reset mid-operation with three transfers in flight.
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b01, 1'b1, 4, 1'b0, '0);
        check("t5_pending_before", int'(pending_o), 3);
        cycle(1'b1, '0, 1'b0, 4, 1'b0, '0);
        rsp_ready_i = '1; req_valid_i = 2'b11; req_ready_i = 1'b0;
        #1;
        check("t5_pending_cleared", int'(pending_o), 0);
        check("t5_rsp_valid_o", int'(rsp_valid_o), 0);
        check("t5_rsp_ready_o", int'(rsp_ready_o), 0);
        check("t5_rr_reset_idx", int'(req_idx_o), 0);

        // Stalled presentation of requester 0 while requester 1 raises valid.
        cycle(1'b0, 2'b01, 1'b1, 4, 1'b0, '0);
        cycle(1'b0, 2'b01, 1'b0, 4, 1'b0, '0);
        req_valid_i = 2'b11;
        #1;
`ifdef STREAM_THROTTLE_ARBITER_LOCK_EN
        check("t6_locked_idx", int'(req_idx_o), 0);
`else
        check("t6_rr_switch_idx", int'(req_idx_o), 1);
`endif
        cycle(1'b0, 2'b11, 1'b0, 4, 1'b0, '0);
        cycle(1'b0, 2'b11, 1'b1, 4, 1'b0, '0);
        drain();

        // Randomized traffic; requesters hold valid until granted.
        hold = '0;
        cr   = 4;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) cr = $urandom_range(0, 7);
            rv = hold;
            if ($urandom_range(0, 2) == 0) rv = rv | N'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                cycle(1'b1, '0, 1'b0, cr, 1'b0, '0);
                hold = '0;
            end else begin
                cycle(1'b0, rv, $urandom_range(0, 3) != 0, cr,
                      (m_fifo.size() != 0) && ($urandom_range(0, 1) == 1), N'($urandom));
                hold = rv;
                if (last_grant >= 0) hold[last_grant] = 1'b0;
            end
        end
        drain();
        cycle(1'b0, '0, 1'b0, 4, 1'b0, '0);
        mon_en = 1'b0;
        check("sb_req_leftover", sb_req.size(), 0);
        check("sb_rsp_leftover", sb_rsp.size(), 0);
        check("final_pending", int'(pending_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
